// File: rtl/rv32i_store_buffer_pkg.sv
// Shared types and helpers for the MEM-stage store buffer.
package rv32i_store_buffer_pkg;

    localparam int unsigned SbDepth     = 4;
    localparam int unsigned SbWidth     = 32;
    localparam int unsigned SbAddrWidth = 32;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] Funct3B  = 3'b000;
    localparam logic [2:0] Funct3H  = 3'b001;
    localparam logic [2:0] Funct3W  = 3'b010;
    localparam logic [2:0] Funct3Bu = 3'b100;
    localparam logic [2:0] Funct3Hu = 3'b101;

    typedef struct packed {
        logic [SbAddrWidth-1:0] addr;
        logic [SbWidth-1:0]     data;
        logic [2:0]             func3;
    } sb_entry_t;

    // Halfwords need an even address, words a 4-byte aligned one; other codes never fault.
    function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] addr_lo);
        logic mis;
        unique case (func3)
            Funct3H, Funct3Hu: mis = addr_lo[0];
            Funct3W:           mis = (addr_lo != 2'b00);
            default:           mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Only SB/SH/SW are real stores; anything else with we=1 is dropped.
    function automatic logic is_store_f3(input logic [2:0] func3);
        return (func3 == Funct3B) || (func3 == Funct3H) || (func3 == Funct3W);
    endfunction

endpackage

// File: rtl/rv32i_store_buffer_if.sv
// Pipeline request and data-memory port bundle for the store buffer.
interface rv32i_store_buffer_if
    import rv32i_store_buffer_pkg::*;
#(
    parameter int unsigned WIDTH      = SbWidth,
    parameter int unsigned ADDR_WIDTH = SbAddrWidth
) ();
    logic                  i_req_valid;
    logic                  i_req_we;
    logic [ADDR_WIDTH-1:0] i_req_addr;
    logic [WIDTH-1:0]      i_req_data;
    logic [2:0]            i_req_func3;
    logic                  i_fence;
    logic                  o_stall;
    logic                  o_misaligned;
    logic [WIDTH-1:0]      o_load_data;
    logic                  o_empty;
    logic                  o_dm_we;
    logic [ADDR_WIDTH-1:0] o_dm_addr;
    logic [WIDTH-1:0]      o_dm_data;
    logic [2:0]            o_dm_func3;
    logic [WIDTH-1:0]      i_dm_data;

    // Store buffer side
    modport slave (
        input  i_req_valid, i_req_we, i_req_addr, i_req_data, i_req_func3, i_fence, i_dm_data,
        output o_stall, o_misaligned, o_load_data, o_empty, o_dm_we, o_dm_addr, o_dm_data,
               o_dm_func3
    );

    // Pipeline plus memory side
    modport master (
        output i_req_valid, i_req_we, i_req_addr, i_req_data, i_req_func3, i_fence, i_dm_data,
        input  o_stall, o_misaligned, o_load_data, o_empty, o_dm_we, o_dm_addr, o_dm_data,
               o_dm_func3
    );
endinterface

// File: rtl/rv32i_store_buffer_fifo.sv
// Circular store queue with per-entry word-address match for load hazard detection.
module rv32i_store_buffer_fifo
    import rv32i_store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = SbDepth
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  sb_entry_t              push_entry_i,
    input  logic                   pop_i,
    input  logic [SbAddrWidth-3:0] cmp_waddr_i,
    output sb_entry_t              head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [DEPTH-1:0]       match_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    sb_entry_t        entry_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PtrW-1:0]  head_q;
    logic [PtrW-1:0]  tail_q;
    logic [CntW-1:0]  count_q;

    // Pointers, count and valid bits; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (pop_i) begin
                head_q          <= head_q + PtrW'(1);
                valid_q[head_q] <= 1'b0;
            end
            if (push_i) begin
                tail_q          <= tail_q + PtrW'(1);
                valid_q[tail_q] <= 1'b1;
            end
            count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
        end
    end

    // Entry payload needs no reset: valid_q gates every use of it
    always_ff @(posedge clk) begin
        if (push_i) begin
            entry_q[tail_q] <= push_entry_i;
        end
    end

    // Word-address compare against every live entry
    always_comb begin
        match_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            match_o[i] = valid_q[i] && (entry_q[i].addr[SbAddrWidth-1:2] == cmp_waddr_i);
        end
    end

    assign head_o  = entry_q[head_q];
    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/rv32i_store_buffer.sv
// MEM-stage store buffer: queues stores, drains them in load-free cycles, stalls on hazards.
module rv32i_store_buffer
    import rv32i_store_buffer_pkg::*;
#(
    parameter int unsigned WIDTH      = SbWidth,
    parameter int unsigned ADDR_WIDTH = SbAddrWidth,
    parameter int unsigned DEPTH      = SbDepth
) (
    input logic                 clk,
    input logic                 rst,
    rv32i_store_buffer_if.slave bus
);
    logic             req_mis;
    logic             req_load;
    logic             req_store;
    logic             hazard;
    logic             load_own;
    logic             stall;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [DEPTH-1:0] match;
    sb_entry_t        head;
    sb_entry_t        new_entry;

    assign new_entry = '{addr: bus.i_req_addr, data: bus.i_req_data, func3: bus.i_req_func3};

    rv32i_store_buffer_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_entry_i (new_entry),
        .pop_i        (pop),
        .cmp_waddr_i  (bus.i_req_addr[ADDR_WIDTH-1:2]),
        .head_o       (head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .match_o      (match)
    );

    // Classify the request, then derive stall and enqueue
    always_comb begin
        req_mis   = bus.i_req_valid
                    && is_misaligned(bus.i_req_func3, bus.i_req_addr[1:0])
                    && (!bus.i_req_we || is_store_f3(bus.i_req_func3));
        req_load  = bus.i_req_valid && !bus.i_req_we && !req_mis;
        req_store = bus.i_req_valid && bus.i_req_we && !req_mis && is_store_f3(bus.i_req_func3);
        hazard    = req_load && (|match);
        load_own  = req_load && !hazard;
        stall     = (req_store && fifo_full) || hazard || (bus.i_fence && !fifo_empty);
        push      = req_store && !fifo_full && !stall;
    end

    // Memory port mux: a clean load wins, otherwise the head entry drains
    always_comb begin
        bus.o_dm_we    = 1'b0;
        bus.o_dm_addr  = '0;
        bus.o_dm_data  = '0;
        bus.o_dm_func3 = '0;
        pop            = 1'b0;
        if (load_own) begin
            bus.o_dm_addr  = bus.i_req_addr;
            bus.o_dm_func3 = bus.i_req_func3;
        end else if (!fifo_empty) begin
            bus.o_dm_we    = 1'b1;
            bus.o_dm_addr  = head.addr;
            bus.o_dm_data  = head.data;
            bus.o_dm_func3 = head.func3;
            pop            = 1'b1;
        end
    end

    assign bus.o_stall      = stall;
    assign bus.o_misaligned = req_mis;
    assign bus.o_empty      = fifo_empty;
    assign bus.o_load_data  = bus.i_dm_data;

endmodule
